memc3_reset_sequencer: RTL and testbench
========================================

MEMC3_RESET_SEQUENCER -- requirements
Module: memc3_reset_sequencer

Interface
REQ-001 Parameter NUM_DOMAINS, default 4, number of independent reset outputs, legal range 1..8.
REQ-002 Parameter RST_SYNC_NUM, default 25, hold cycles after lock qualification, legal range 2..255.
REQ-003 Parameter STAGGER_CYCLES, default 16, cycles between consecutive domain releases, legal range 0..255.
REQ-004 Parameter LOCK_FILTER, default 8, consecutive qualified-lock cycles required, legal range 1..255.
REQ-005 Parameter LOCK_MODE, default 0; 0 = sticky power-up lock, 1 = lock loss re-runs the sequence.
REQ-006 clk0  input  1  sequencer clock; all state is on the rising edge.
REQ-007 sys_rst  input  1  asynchronous, active-high reset.
REQ-008 pll_lock  input  1  PLL LOCKED, asynchronous to clk0.
REQ-009 bufpll_lock  input  1  BUFPLL_MCB LOCK, asynchronous to clk0.
REQ-010 soft_rst  input  1  single-cycle synchronous request to re-run the sequence.
REQ-011 rst_out  output  NUM_DOMAINS  per-domain active-high reset; bit 0 released first.
REQ-012 async_rst  output  1  high whenever the lock is unqualified.
REQ-013 seq_done  output  1  high only in RUN.
REQ-014 seq_state  output  3  current state encoding.

Function
REQ-015 Synchronize pll_lock & bufpll_lock through a 2-flop synchronizer to form lock_s.
REQ-016 States and encodings: WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3.
REQ-017 WAIT_LOCK: a filter counter counts consecutive lock_s=1 cycles and clears on lock_s=0; when the count reaches LOCK_FILTER, go to HOLD.
REQ-018 HOLD: hold rst_out all-ones for exactly RST_SYNC_NUM cycles, then go to RELEASE.
REQ-019 RELEASE: clear rst_out[0] on the first RELEASE cycle; clear rst_out[i] exactly i*STAGGER_CYCLES cycles later.
REQ-020 RELEASE: go to RUN on the cycle after the final bit clears; with STAGGER_CYCLES=0, clear all bits together.
REQ-021 rst_out bits never reassert individually; reassertion is always all-ones, registered, on entry to WAIT_LOCK or HOLD.
REQ-022 soft_rst=1 in RELEASE or RUN: go to HOLD next cycle, set rst_out all-ones, and restart the hold count; ignore soft_rst in WAIT_LOCK and HOLD.
REQ-023 LOCK_MODE=0: after the first entry to HOLD, latch lock qualification until sys_rst; ignore later lock_s drops.
REQ-024 LOCK_MODE=1: lock_s=0 in HOLD, RELEASE or RUN forces WAIT_LOCK next cycle and sets rst_out all-ones.
REQ-025 Lock loss takes priority over soft_rst when both occur in the same cycle.
REQ-026 async_rst = sys_rst OR (qualified-lock latch low); the path from sys_rst to async_rst is combinational.
REQ-027 Size all counters as $clog2 of their maximum value plus 1; counters saturate and never wrap.

Reset
REQ-028 sys_rst=1 asynchronously forces: state WAIT_LOCK, rst_out all-ones, seq_done 0, seq_state 0, synchronizers and counters 0, qualified-lock latch 0.
REQ-029 Reset deassertion is synchronous; the sequence starts from WAIT_LOCK.
REQ-030 sys_rst asserted mid-sequence aborts the sequence immediately, with no partial release.

Configuration
REQ-031 When MEMC3_RSTSEQ_LOSS_CNT_EN is defined:
- add output lock_loss_cnt, 8 bits, reset 0;
- increment it on each falling edge of lock_s after the first qualification, in both LOCK_MODE values;
- saturate at 255.
REQ-032 When MEMC3_RSTSEQ_LOSS_CNT_EN is undefined, the port and its logic are absent and all other behaviour is identical.

Verification (NUM_DOMAINS=4, RST_SYNC_NUM=25, STAGGER_CYCLES=8, LOCK_FILTER=4)
REQ-033 Release sirst_rst then both locks high -> HOLD 6 cycles after lock (2 sync + 4 filter); rst_out[0] falls 25 cycles later; bits 1, 2, 3 fall at +8, +16, +24; seq_done rises 1 cycle after bit 3.
REQ-034 Lock pulse high for 3 cycles, low, then stable -> filter restarts; no HOLD entry until 4 consecutive lock_s cycles.
REQ-035 LOCK_MODE=0, pll_lock dropped in RUN -> rst_out stays 0000 and seq_done stays 1; with the macro defined, lock_loss_cnt=1.
REQ-036 LOCK_MODE=1, bufpll_lock dropped during RELEASE after bit 1 falls -> rst_out=1111 and state WAIT_LOCK after the sync delay; full sequence re-runs when lock returns.
REQ-037 soft_rst pulse in RUN -> rst_out=1111 next cycle, then the full 25-cycle hold and staggered release.
REQ-038 sys_rst pulsed mid-HOLD -> rst_out=1111, async_rst=1 in the same cycle with no clock edge, state 0.

Source files
------------

// File: rtl/memc3_reset_sequencer.sv
// Power-up reset sequencer for the MCB: qualifies PLL/BUFPLL lock, holds all domains
// in reset, then releases them one by one. `define MEMC3_RSTSEQ_LOSS_CNT_EN adds lock_loss_cnt.
module memc3_reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int RST_SYNC_NUM   = 25,
  parameter int STAGGER_CYCLES = 16,
  parameter int LOCK_FILTER    = 8,
  parameter int LOCK_MODE      = 0
) (
  input  logic                   clk0,
  input  logic                   sys_rst,
  input  logic                   pll_lock,
  input  logic                   bufpll_lock,
  input  logic                   soft_rst,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   async_rst,
  output logic                   seq_done,
  output logic [2:0]             seq_state
`ifdef MEMC3_RSTSEQ_LOSS_CNT_EN
  ,
  output logic [7:0]             lock_loss_cnt
`endif
);

  localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
  localparam int HOLD_W  = $clog2(RST_SYNC_NUM + 1);
  localparam int REL_MAX = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int REL_W   = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;

  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOCK_FILTER);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_SYNC_NUM - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_MAX);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } state_t;

  state_t                 state, state_nxt;
  logic                   lock_q1, lock_q2, lock_s, lock_lost;
  logic                   qual, qual_nxt;
  logic [FILT_W-1:0]      filt_cnt, filt_nxt;
  logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
  logic [REL_W-1:0]       rel_cnt, rel_nxt, rel_inc, rel_sel;
  logic [NUM_DOMAINS-1:0] rst_nxt, clr_mask;

  // Both lock inputs are combined first so a single synchronizer qualifies them together.
  always_ff @(posedge clk0 or posedge sys_rst) begin
    if (sys_rst) begin
      lock_q1 <= 1'b0;
      lock_q2 <= 1'b0;
    end else begin
      lock_q1 <= pll_lock & bufpll_lock;
      lock_q2 <= lock_q1;
    end
  end

  assign lock_s    = lock_q2;
  assign lock_lost = (LOCK_MODE == 1) && !lock_s;

  assign rel_inc = (rel_cnt == REL_LAST) ? rel_cnt : rel_cnt + REL_W'(1);

  // Domain i is released once the release counter reaches i*STAGGER_CYCLES.
  always_comb begin
    rel_sel  = (state == RELEASE) ? rel_inc : '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (i * STAGGER_CYCLES <= int'(rel_sel)) clr_mask[i] = 1'b1;
    end
  end

  // soft_rst is a one-cycle request with no acknowledge: it is acted on only in
  // RELEASE/RUN and silently dropped elsewhere; lock loss wins over it.
  always_comb begin
    state_nxt = state;
    filt_nxt  = filt_cnt;
    hold_nxt  = hold_cnt;
    rel_nxt   = rel_cnt;
    rst_nxt   = rst_out;
    qual_nxt  = qual;
    case (state)
      WAIT_LOCK: begin
        rst_nxt = '1;
        if (!lock_s)                 filt_nxt = '0;
        else if (filt_cnt != FILT_MAX) filt_nxt = filt_cnt + FILT_W'(1);
        if (lock_s && (filt_cnt >= FILT_LAST)) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
          qual_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (lock_lost) begin
          state_nxt = WAIT_LOCK;
          filt_nxt  = '0;
          rst_nxt   = '1;
          qual_nxt  = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RELEASE;
          rel_nxt   = '0;
          rst_nxt   = rst_out & ~clr_mask;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      RELEASE, RUN: begin
        if (lock_lost) begin
          state_nxt = WAIT_LOCK;
          filt_nxt  = '0;
          rst_nxt   = '1;
          qual_nxt  = 1'b0;
        end else if (soft_rst) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
          rst_nxt   = '1;
        end else if (state == RELEASE) begin
          if (rst_out == '0) begin
            state_nxt = RUN;
          end else begin
            rel_nxt = rel_inc;
            rst_nxt = rst_out & ~clr_mask;
          end
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        filt_nxt  = '0;
        rst_nxt   = '1;
      end
    endcase
  end

  always_ff @(posedge clk0 or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= WAIT_LOCK;
      filt_cnt <= '0;
      hold_cnt <= '0;
      rel_cnt  <= '0;
      rst_out  <= '1;
      qual     <= 1'b0;
    end else begin
      state    <= state_nxt;
      filt_cnt <= filt_nxt;
      hold_cnt <= hold_nxt;
      rel_cnt  <= rel_nxt;
      rst_out  <= rst_nxt;
      qual     <= qual_nxt;
    end
  end

  assign async_rst = sys_rst | ~qual;
  assign seq_done  = (state == RUN);
  assign seq_state = state;

`ifdef MEMC3_RSTSEQ_LOSS_CNT_EN
  logic lock_s_d, qual_seen;

  // Counts lock_s falling edges once lock has been qualified at least once.
  always_ff @(posedge clk0 or posedge sys_rst) begin
    if (sys_rst) begin
      lock_s_d      <= 1'b0;
      qual_seen     <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      lock_s_d  <= lock_s;
      qual_seen <= qual_seen | qual;
      if ((qual_seen | qual) && lock_s_d && !lock_s && (lock_loss_cnt != 8'hff))
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memc3_reset_sequencer.sv
// Bench for memc3_reset_sequencer: a sticky-lock and a lock-loss instance share stimulus;
// each output change is matched against a queue of expected {cycle, outputs} events.
module tb_memc3_reset_sequencer;

  localparam int HOLD_N = 25;
  localparam int STG    = 8;
  localparam logic [8:0] RST_REC = {3'd0, 4'hf, 1'b0, 1'b1};

  logic clk, sys_rst, pll_lock, bufpll_lock, soft_rst;
  logic [3:0] rst_out0, rst_out1;
  logic       async_rst0, async_rst1, seq_done0, seq_done1;
  logic [2:0] seq_state0, seq_state1;
`ifdef MEMC3_RSTSEQ_LOSS_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [40:0] exp_q0[$];
  logic [40:0] exp_q1[$];
  logic [8:0]  obs0, obs1;
  logic [8:0]  prev0 = RST_REC;
  logic [8:0]  prev1 = RST_REC;

  memc3_reset_sequencer #(
    .NUM_DOMAINS(4), .RST_SYNC_NUM(HOLD_N), .STAGGER_CYCLES(STG), .LOCK_FILTER(4), .LOCK_MODE(0)
  ) dut0 (
    .clk0(clk), .sys_rst(sys_rst), .pll_lock(pll_lock), .bufpll_lock(bufpll_lock),
    .soft_rst(soft_rst), .rst_out(rst_out0), .async_rst(async_rst0), .seq_done(seq_done0),
    .seq_state(seq_state0)
`ifdef MEMC3_RSTSEQ_LOSS_CNT_EN
    , .lock_loss_cnt(cnt0)
`endif
  );

  memc3_reset_sequencer #(
    .NUM_DOMAINS(4), .RST_SYNC_NUM(HOLD_N), .STAGGER_CYCLES(STG), .LOCK_FILTER(4), .LOCK_MODE(1)
  ) dut1 (
    .clk0(clk), .sys_rst(sys_rst), .pll_lock(pll_lock), .bufpll_lock(bufpll_lock),
    .soft_rst(soft_rst), .rst_out(rst_out1), .async_rst(async_rst1), .seq_done(seq_done1),
    .seq_state(seq_state1)
`ifdef MEMC3_RSTSEQ_LOSS_CNT_EN
    , .lock_loss_cnt(cnt1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs0 = {seq_state0, rst_out0, seq_done0, async_rst0};
  assign obs1 = {seq_state1, rst_out1, seq_done1, async_rst1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] rec(input logic [2:0] st, input logic [3:0] r,
                                     input logic d, input logic a);
    return {st, r, d, a};
  endfunction

  // driver tasks
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int d, input int c, input logic [8:0] v);
    if (d == 0) exp_q0.push_back({c, v});
    else        exp_q1.push_back({c, v});
  endtask

  // Full hold + staggered release starting with HOLD entry on edge h.
  task automatic push_seq(input int d, input int h);
    push(d, h,                 rec(3'd1, 4'hf, 1'b0, 1'b0));
    push(d, h + HOLD_N,        rec(3'd2, 4'he, 1'b0, 1'b0));
    push(d, h + HOLD_N + STG,  rec(3'd2, 4'hc, 1'b0, 1'b0));
    push(d, h + HOLD_N + 2*STG, rec(3'd2, 4'h8, 1'b0, 1'b0));
    push(d, h + HOLD_N + 3*STG, rec(3'd2, 4'h0, 1'b0, 1'b0));
    push(d, h + HOLD_N + 3*STG + 1, rec(3'd3, 4'h0, 1'b1, 1'b0));
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (obs0 !== prev0) begin
      if (exp_q0.size() == 0) check("d0_unexpected", {cyc, obs0}, {cyc, prev0});
      else check("d0_event", {cyc, obs0}, exp_q0.pop_front());
      prev0 = obs0;
    end
    if (obs1 !== prev1) begin
      if (exp_q1.size() == 0) check("d1_unexpected", {cyc, obs1}, {cyc, prev1});
      else check("d1_event", {cyc, obs1}, exp_q1.pop_front());
      prev1 = obs1;
    end
  end

  initial begin
    int t;
    sys_rst = 1'b1; pll_lock = 1'b0; bufpll_lock = 1'b0; soft_rst = 1'b0;
    #1;
    check("reset_d0", obs0, RST_REC);
    check("reset_d1", obs1, RST_REC);
    go_to(3);
    sys_rst = 1'b0;

    // 3-cycle lock glitch must not qualify; stable lock then runs the sequence
    go_to(6);  pll_lock = 1'b1; bufpll_lock = 1'b1;
    go_to(9);  pll_lock = 1'b0; bufpll_lock = 1'b0;
    go_to(20); pll_lock = 1'b1; bufpll_lock = 1'b1;
    push_seq(0, 26); push_seq(1, 26);
    go_to(26 + 55);

    // soft reset from RUN
    t = cyc;
    soft_rst = 1'b1;
    push_seq(0, t + 1); push_seq(1, t + 1);
    go_to(t + 1); soft_rst = 1'b0;
    go_to(t + 60);

    // bufpll_lock lost in RELEASE after bit 1 falls
    t = cyc + 1;
    soft_rst = 1'b1;
    push_seq(0, t);
    push(1, t,               rec(3'd1, 4'hf, 1'b0, 1'b0));
    push(1, t + HOLD_N,      rec(3'd2, 4'he, 1'b0, 1'b0));
    push(1, t + HOLD_N + STG, rec(3'd2, 4'hc, 1'b0, 1'b0));
    go_to(t); soft_rst = 1'b0;
    go_to(t + 35); bufpll_lock = 1'b0;
    push(1, t + 38, rec(3'd0, 4'hf, 1'b0, 1'b1));
    go_to(t + 60); bufpll_lock = 1'b1;
    push_seq(1, t + 66);
    go_to(t + 66 + 55);

    // pll_lock lost in RUN: sticky instance unaffected
    t = cyc;
    pll_lock = 1'b0;
    push(1, t + 3, rec(3'd0, 4'hf, 1'b0, 1'b1));
    go_to(t + 10); pll_lock = 1'b1;
    push_seq(1, t + 16);
    go_to(t + 16 + 55);
`ifdef MEMC3_RSTSEQ_LOSS_CNT_EN
    check("d0_loss_cnt", cnt0, 2);
    check("d1_loss_cnt", cnt1, 2);
`endif

    // lock loss and soft_rst in the same cycle; soft_rst in HOLD ignored
    t = cyc;
    bufpll_lock = 1'b0;
    push(1, t + 3, rec(3'd0, 4'hf, 1'b0, 1'b1));
    push_seq(0, t + 3);
    go_to(t + 2); soft_rst = 1'b1;
    go_to(t + 3); soft_rst = 1'b0;
    go_to(t + 10); bufpll_lock = 1'b1;
    push_seq(1, t + 16);
    go_to(t + 20); soft_rst = 1'b1;
    go_to(t + 21); soft_rst = 1'b0;
    go_to(t + 16 + 55);

    // sys_rst pulsed mid-HOLD
    t = cyc;
    soft_rst = 1'b1;
    push(0, t + 1, rec(3'd1, 4'hf, 1'b0, 1'b0));
    push(1, t + 1, rec(3'd1, 4'hf, 1'b0, 1'b0));
    go_to(t + 1); soft_rst = 1'b0;
    go_to(t + 11);
    push(0, t + 11, RST_REC);
    push(1, t + 11, RST_REC);
    sys_rst = 1'b1;
    #1;
    check("d0_async_now", {async_rst0, rst_out0, seq_state0}, {1'b1, 4'hf, 3'd0});
    check("d1_async_now", {async_rst1, rst_out1, seq_state1}, {1'b1, 4'hf, 3'd0});
    go_to(t + 14); sys_rst = 1'b0;
    push_seq(0, t + 20); push_seq(1, t + 20);
    go_to(t + 20 + 55);
`ifdef MEMC3_RSTSEQ_LOSS_CNT_EN
    check("d0_loss_cnt_rst", cnt0, 0);
`endif

    // final report
    check("d0_pending", exp_q0.size(), 0);
    check("d1_pending", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
